key_debounce: RTL and testbench
===============================

Name: key_debounce

Overview:
Debounces and edge-detects the raw board push-buttons feeding the logic blocks: key_in pin -> clean level plus single-cycle press/release events.
Per-key synchroniser, stability counter and state machine.
Sits between the FPGA key pins and the consumer logic, such as the LED logic. Consumers see key_level and the event pulses instead of the raw pins.

Parameters:
NUM_KEYS, 2, number of independent keys; each has its own synchroniser, counter and FSM.
CNT_MAX, 1_000_000, consecutive stable cycles required to accept a level change (20 ms at 50 MHz); must be >= 2.
KEY_ACTIVE, 0, pin level meaning "pressed" (0 = active-low buttons).
LONG_MAX, 50_000_000, held cycles before a long-press event; used only with KEY_LONG_PRESS_EN.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  asynchronous, active-high reset.
key_in  input  NUM_KEYS  raw, asynchronous button pins.
key_level  output  NUM_KEYS  debounced state per key; 1 = pressed, regardless of KEY_ACTIVE.
key_press  output  NUM_KEYS  one-cycle pulse when a key is accepted as pressed.
key_release  output  NUM_KEYS  one-cycle pulse when a key is accepted as released.
key_long  output  NUM_KEYS  one-cycle long-press pulse (optional feature; constant 0 when the feature is disabled).

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high. All registers clear immediately on rst=1, independent of clk.
- Reset values:
  - key_level, key_press, key_release, key_long = 0.
  - Synchroniser flops = ~KEY_ACTIVE, i.e. the released pin level.
  - Counters = 0; FSM = UP.
- Synchroniser: 2-flop chain per key (s1, s2). Logical sample p = (s2 == KEY_ACTIVE).
- Counter:
  - Width $clog2(CNT_MAX+1); no wrap.
  - Increments every cycle p != key_level; cleared to 0 on any cycle p == key_level.
  - A single-cycle bounce therefore restarts qualification.
- FSM per key, states UP, DEB_DN, DOWN, DEB_UP:
  - UP: p=1 -> DEB_DN.
  - DEB_DN: p=0 -> UP (count cleared); count reaches CNT_MAX-1 with p=1 -> DOWN, key_level<=1, key_press<=1 for one cycle, count<=0.
  - DOWN: p=0 -> DEB_UP.
  - DEB_UP: p=1 -> DOWN; count reaches CNT_MAX-1 with p=0 -> UP, key_level<=0, key_release<=1 for one cycle, count<=0.
- Latency: a clean pin edge at clock edge 0 is reflected in key_level and the pulse after edge 2+CNT_MAX. All outputs are registered.
- Events:
  - key_press and key_release never assert together for one key.
  - Consecutive same-direction events cannot occur without an opposite event between them.
- Keys are fully independent; simultaneous events on different keys are all reported in the same cycle.
- Reset mid-qualification: the count is discarded and no pulse is generated. After release of rst, a key held down is re-qualified as a fresh press after 2+CNT_MAX cycles.

Optional Feature:
KEY_LONG_PRESS_EN
- Defined:
  - A per-key hold counter, width $clog2(LONG_MAX+1), counts while the FSM is in DOWN or DEB_UP.
  - On reaching LONG_MAX-1, key_long pulses for one cycle, once per press; the counter saturates.
  - The hold counter clears on transition to UP or on rst.
  - Bounce back into DOWN from DEB_UP does not clear it.
- Undefined: no hold counter is built and key_long is tied to 0. The port list is unchanged.

Test Plan:
1. Bench configuration: NUM_KEYS=2, CNT_MAX=8, LONG_MAX=32, KEY_ACTIVE=0. Reset: assert rst mid-cycle -> all outputs 0 immediately, before the next clk edge.
2. Clean press: key_in[0] 1->0 before edge 0, held -> key_level[0]=1 and key_press[0]=1 after edge 10. key_press[0]=0 after edge 11. key_in[1] unaffected.
3. Bounce: key_in[0] low 5 cycles, high 1 cycle, then low -> no pulse at the original deadline. Press is accepted 8 stable cycles after the last bounce, exactly one key_press.
4. Release: from pressed, key_in[0] 0->1 held -> key_release[0] after 10 edges, key_level[0]=0. Glitches of up to 7 cycles while held down produce no event.
5. Simultaneous keys plus reset: both keys pressed on the same edge -> key_press=2'b11 in one cycle. rst pulsed at count 4 of a later press -> no pulse, then re-qualifies 10 edges after rst drops.
6. Long press: with KEY_LONG_PRESS_EN defined, key held 50 cycles -> one key_long pulse at 32 cycles after key_press, none thereafter. Without the macro, key_long stays 0 throughout.

Source files
------------

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - per-key synchroniser, stability counter and FSM giving clean level plus press/release pulses.
// Optional long-press pulse generator is built only when KEY_LONG_PRESS_EN is defined.
module key_debounce #(
   parameter int NUM_KEYS   = 2,
   parameter int CNT_MAX    = 1_000_000,
   parameter bit KEY_ACTIVE = 1'b0,
   parameter int LONG_MAX   = 50_000_000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_KEYS-1:0] key_in,
   output logic [NUM_KEYS-1:0] key_level,
   output logic [NUM_KEYS-1:0] key_press,
   output logic [NUM_KEYS-1:0] key_release,
   output logic [NUM_KEYS-1:0] key_long
);

   localparam int CW = $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);

   typedef enum logic [1:0] {UP, DEB_DN, DOWN, DEB_UP} state_t;

   state_t              state_q [NUM_KEYS];
   state_t              state_d [NUM_KEYS];
   logic [CW-1:0]       cnt_q   [NUM_KEYS];
   logic [CW-1:0]       cnt_d   [NUM_KEYS];
   logic [NUM_KEYS-1:0] s1_q, s2_q;
   logic [NUM_KEYS-1:0] level_q, level_d;
   logic [NUM_KEYS-1:0] press_q, press_d;
   logic [NUM_KEYS-1:0] release_q, release_d;
   logic [NUM_KEYS-1:0] p;

   // p is the pressed sample in logical polarity, independent of pin polarity
   assign p = KEY_ACTIVE ? s2_q : ~s2_q;

   always_comb begin
      for (int i = 0; i < NUM_KEYS; i++) begin
         state_d[i]   = state_q[i];
         cnt_d[i]     = cnt_q[i];
         level_d[i]   = level_q[i];
         press_d[i]   = 1'b0;
         release_d[i] = 1'b0;
         case (state_q[i])
            UP: begin
               cnt_d[i] = '0;
               if (p[i]) state_d[i] = DEB_DN;
            end
            DEB_DN: begin
               if (!p[i]) begin
                  state_d[i] = UP;
                  cnt_d[i]   = '0;
               end else if (cnt_q[i] == CNT_LAST) begin
                  state_d[i] = DOWN;
                  level_d[i] = 1'b1;
                  press_d[i] = 1'b1;
                  cnt_d[i]   = '0;
               end else begin
                  cnt_d[i] = cnt_q[i] + 1'b1;
               end
            end
            DOWN: begin
               cnt_d[i] = '0;
               if (!p[i]) state_d[i] = DEB_UP;
            end
            DEB_UP: begin
               if (p[i]) begin
                  state_d[i] = DOWN;
                  cnt_d[i]   = '0;
               end else if (cnt_q[i] == CNT_LAST) begin
                  state_d[i]   = UP;
                  level_d[i]   = 1'b0;
                  release_d[i] = 1'b1;
                  cnt_d[i]     = '0;
               end else begin
                  cnt_d[i] = cnt_q[i] + 1'b1;
               end
            end
            default: begin
               state_d[i] = UP;
               cnt_d[i]   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q      <= {NUM_KEYS{~KEY_ACTIVE}};
         s2_q      <= {NUM_KEYS{~KEY_ACTIVE}};
         level_q   <= '0;
         press_q   <= '0;
         release_q <= '0;
         for (int i = 0; i < NUM_KEYS; i++) begin
            state_q[i] <= UP;
            cnt_q[i]   <= '0;
         end
      end else begin
         s1_q      <= key_in;
         s2_q      <= s1_q;
         level_q   <= level_d;
         press_q   <= press_d;
         release_q <= release_d;
         for (int i = 0; i < NUM_KEYS; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
      end
   end

   assign key_level   = level_q;
   assign key_press   = press_q;
   assign key_release = release_q;

`ifdef KEY_LONG_PRESS_EN
   localparam int LW = $clog2(LONG_MAX + 1);
   localparam logic [LW-1:0] HOLD_SAT  = LW'(LONG_MAX);
   localparam logic [LW-1:0] HOLD_LAST = LW'(LONG_MAX - 1);

   logic [LW-1:0]       hold_q [NUM_KEYS];
   logic [LW-1:0]       hold_d [NUM_KEYS];
   logic [NUM_KEYS-1:0] long_q, long_d;

   // Saturating at LONG_MAX keeps the pulse to once per press, even across DEB_UP bounces
   always_comb begin
      for (int i = 0; i < NUM_KEYS; i++) begin
         hold_d[i] = hold_q[i];
         long_d[i] = 1'b0;
         if ((state_q[i] == DOWN) || (state_q[i] == DEB_UP)) begin
            if (state_d[i] == UP) begin
               hold_d[i] = '0;
            end else if (hold_q[i] != HOLD_SAT) begin
               hold_d[i] = hold_q[i] + 1'b1;
               if (hold_q[i] == HOLD_LAST) long_d[i] = 1'b1;
            end
         end else begin
            hold_d[i] = '0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         long_q <= '0;
         for (int i = 0; i < NUM_KEYS; i++) hold_q[i] <= '0;
      end else begin
         long_q <= long_d;
         for (int i = 0; i < NUM_KEYS; i++) hold_q[i] <= hold_d[i];
      end
   end

   assign key_long = long_q;
`else
   logic long_max_unused;
   assign long_max_unused = ^LONG_MAX;
   assign key_long        = '0;
`endif

endmodule

// File: tb/tb_key_debounce.sv
// tb/tb_key_debounce.sv - directed self-checking bench for key_debounce (CNT_MAX=8, LONG_MAX=32, active-low keys).
// Long-press expectations follow KEY_LONG_PRESS_EN.
module tb_key_debounce;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [1:0] key_in = 2'b11;
   logic [1:0] key_level, key_press, key_release, key_long;

   int tests = 0;
   int fails = 0;
   int press_cnt, press_at, long_cnt, long_at, rel_cnt;

   key_debounce #(
      .NUM_KEYS  (2),
      .CNT_MAX   (8),
      .KEY_ACTIVE(1'b0),
      .LONG_MAX  (32)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .key_in     (key_in),
      .key_level  (key_level),
      .key_press  (key_press),
      .key_release(key_release),
      .key_long   (key_long)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // async reset before any clock edge
      #1 rst = 1'b1;
      #1;
      check("reset_outputs", {24'd0, key_level, key_press, key_release, key_long}, 32'd0);
      step();
      step();
      rst = 1'b0;
      repeat (3) step();
      check("idle_level", key_level, 2'b00);

      // clean press of key 0
      key_in[0] = 1'b0;
      repeat (10) step();
      check("press_before_deadline_level", key_level, 2'b00);
      check("press_before_deadline_pulse", key_press, 2'b00);
      step();
      check("press_level", key_level, 2'b01);
      check("press_pulse", key_press, 2'b01);
      step();
      check("press_pulse_end", key_press, 2'b00);
      check("press_level_hold", key_level, 2'b01);

      // 7-cycle glitch while held down
      key_in[0] = 1'b1;
      repeat (7) step();
      key_in[0] = 1'b0;
      rel_cnt = 0;
      for (int i = 0; i < 15; i++) begin
         step();
         if (key_release[0]) rel_cnt++;
      end
      check("glitch_no_release", rel_cnt, 0);
      check("glitch_level", key_level, 2'b01);

      // clean release
      key_in[0] = 1'b1;
      repeat (10) step();
      check("release_before_deadline", {key_level, key_release}, {2'b01, 2'b00});
      step();
      check("release_level", key_level, 2'b00);
      check("release_pulse", key_release, 2'b01);
      step();
      check("release_pulse_end", key_release, 2'b00);

      // bounce: low 5, high 1, then low
      key_in[0] = 1'b0;
      repeat (5) step();
      key_in[0] = 1'b1;
      step();
      key_in[0] = 1'b0;
      press_cnt = 0;
      press_at  = 0;
      for (int i = 1; i <= 20; i++) begin
         step();
         if (key_press[0]) begin
            press_cnt++;
            press_at = i;
         end
         if (i == 5) check("bounce_orig_deadline_level", key_level, 2'b00);
      end
      check("bounce_press_count", press_cnt, 1);
      check("bounce_press_time", press_at, 11);

      key_in[0] = 1'b1;
      repeat (12) step();
      check("bounce_release_level", key_level, 2'b00);

      // long hold
      key_in[0] = 1'b0;
      press_cnt = 0;
      press_at  = 0;
      long_cnt  = 0;
      long_at   = 0;
      for (int i = 1; i <= 60; i++) begin
         step();
         if (key_press[0]) begin
            press_cnt++;
            press_at = i;
         end
         if (key_long != 2'b00) begin
            long_cnt++;
            long_at = i;
         end
      end
      check("long_press_count", press_cnt, 1);
      check("long_press_time", press_at, 11);
`ifdef KEY_LONG_PRESS_EN
      check("long_pulse_count", long_cnt, 1);
      check("long_pulse_delay", long_at - press_at, 32);
`else
      check("long_pulse_count_off", long_cnt, 0);
`endif
      key_in[0] = 1'b1;
      repeat (12) step();
      check("long_release_level", key_level, 2'b00);

      // both keys on the same edge
      key_in = 2'b00;
      repeat (10) step();
      check("dual_press_early", key_press, 2'b00);
      step();
      check("dual_press", key_press, 2'b11);
      check("dual_level", key_level, 2'b11);
      key_in = 2'b11;
      repeat (11) step();
      check("dual_release", key_release, 2'b11);
      check("dual_release_level", key_level, 2'b00);
      step();

      // reset at count 4 of a press, then re-qualification
      key_in[0] = 1'b0;
      repeat (7) step();
      rst = 1'b1;
      #1;
      check("midqual_reset_outputs", {24'd0, key_level, key_press, key_release, key_long}, 32'd0);
      step();
      step();
      rst = 1'b0;
      press_cnt = 0;
      press_at  = 0;
      for (int i = 1; i <= 15; i++) begin
         step();
         if (key_press[0]) begin
            press_cnt++;
            press_at = i;
         end
      end
      check("requal_press_count", press_cnt, 1);
      check("requal_press_time", press_at, 11);
      check("requal_level", key_level, 2'b01);

      // reset mid-cycle clears outputs before the next edge
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("midcycle_reset_level", key_level, 2'b00);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
